board_ctrl: RTL and testbench
=============================

Name: board_ctrl

Overview:
Owns the 8x8 star board for the PopStar-style game and sequences every change to it: random fill on new game, flood-fill elimination of the same-colour group under the cursor, gravity collapse, scoring and game-over detection. It replaces the static board array in top. The display path reads the board through a registered read port. The operate block supplies cursor row/col and the eliminate command.

Parameters:
LFSR_SEED, 16'hACE1, nonzero start value of the fill LFSR
NUM_COLORS, 5, number of colours used by fill; legal range 1..5
SCORE_W, 16, score width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
new_game  in  1  pulse; start a fill
cmd_valid  in  1  eliminate request
cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
cmd_row  in  3  cursor row (0 = top)
cmd_col  in  3  cursor column (0 = left)
ld_en  in  1  direct cell write, bench/debug
ld_row  in  3  write row
ld_col  in  3  write column
ld_color  in  3  write value
rd_row  in  3  display read row
rd_col  in  3  display read column
rd_color  out  3  cell value; 0 = empty, 1..5 = colour
busy  out  1  state not IDLE/GAMEOVER
done  out  1  one-cycle pulse, command or fill completed
rejected  out  1  one-cycle pulse, command refused
elim_count  out  7  cells removed by last command
score  out  SCORE_W  accumulated score
game_over  out  1  no legal move remains

Behaviour:
- Reset:
  - Board all 0, mark all 0, LFSR=LFSR_SEED, state IDLE.
  - All outputs 0, except cmd_ready=1 (IDLE, new_game low).
- rd_color: registered, 1-cycle latency, valid in every state. Intermediate board values are visible during FALL.
- States: IDLE, FILL, SEED, MARK, CLEAR, FALL, COMPACT (optional), CHECK, GAMEOVER.
- cmd_ready = (state==IDLE) && !new_game.
- new_game:
  - Accepted in IDLE or GAMEOVER; ignored while busy.
  - Wins over a simultaneous cmd_valid, which is not accepted.
- ld_en: writes the cell only in IDLE/GAMEOVER, otherwise ignored. ld_color values 6 and 7 are stored as 0.
- FILL:
  - 64 cycles, raster order (row-major).
  - Each cycle: cell = (lfsr[7:0] mod NUM_COLORS)+1, then the LFSR advances (Galois, mask 16'hB400).
  - On entry: score=0, elim_count=0, game_over=0.
  - Then CHECK.
- Eliminate command, IDLE accept -> SEED.
- SEED (1 cycle):
  - If the target cell is 0, or has no orthogonal neighbour of equal colour: pulse rejected, return to IDLE.
  - A reject leaves board, score and elim_count unchanged and produces no done.
  - Otherwise mark only the target, go to MARK.
- MARK:
  - One pass per cycle, all 64 cells in parallel.
  - mark' = mark | (cell==target colour && any orthogonal neighbour marked).
  - Stay while any mark changed; the pass with no change goes to CLEAR. Max 63 passes.
- CLEAR (1 cycle):
  - Marked cells set to 0; elim_count = popcount(mark).
  - score += elim_count², saturating at all-ones.
  - Marks cleared.
- FALL:
  - One step per cycle, per column independently.
  - e = bottom-most empty row in the column that has a nonzero cell above it.
  - If e exists: rows 1..e take old row-1, and row 0 becomes 0.
  - Leave FALL on the first cycle where no column moves.
- CHECK (1 cycle):
  - game_over = no orthogonally adjacent pair of equal nonzero cells.
  - Go to GAMEOVER if game_over, else IDLE, and pulse done.
- GAMEOVER: holds until new_game. cmd_ready=0; cmd_valid is ignored with no reject pulse.
- rst mid-operation: immediate return to the reset state. No done or rejected pulse.

Optional Feature:
COL_COMPACT_EN:
- Defined: after FALL, a COMPACT state runs one step per cycle.
  - The leftmost fully empty column c that has a nonempty column to its right is removed.
  - Columns c+1..7 shift left one; column 7 becomes 0.
  - Repeats until no step occurs, then CHECK.
- Undefined: FALL goes directly to CHECK and columns never move.

Test Plan:
- Reset, then cmd (0,0) on the empty board -> rejected=1 for one cycle, done=0, score=0, all rd_color=0.
- Checkerboard ld (colour 1 if row+col even, else 2), cmd (0,0) -> rejected, board unchanged, game_over remains 0.
- Same checkerboard with (7,0)=(7,1)=3, cmd (7,0):
  - elim_count=2, score=4; columns 0 and 1 shifted down one, (0,0)=(0,1)=0.
  - game_over=0, done pulses once.
- All 64 cells ld=1, cmd (3,3):
  - elim_count=64, score=4096, board all 0, game_over=1, cmd_ready=0.
  - A second cmd_valid gets no response.
- NUM_COLORS=1, new_game together with cmd_valid:
  - Command not accepted; busy for FILL (64 cycles) + CHECK.
  - All cells 1, score 0, done pulse, game_over=0.
- Assert rst during MARK of the all-ones case -> next cycle busy=0, board all 0, score 0, no done.
- With COL_COMPACT_EN, column 0 all 1 and the rest checkerboard: cmd (0,0) -> column 0 removed, old column 1 now in column 0, column 7 all 0.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: owner and sequencer of the 8x8 PopStar board.
//
// Handles random fill on new game, flood-fill elimination of the same-colour
// group under the cursor, per-column gravity, scoring and game-over detection.
// Cell index is row*8+col, row 0 at the top. Cell value 0 is empty, 1..5 a colour.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   new_game              pulse, starts a fill (accepted in IDLE/GAMEOVER)
//   cmd_valid/ready       eliminate handshake, cmd_row/cmd_col give the cursor
//   ld_en/row/col/color   direct cell write, honoured in IDLE/GAMEOVER only
//   rd_row/rd_col         display read address, rd_color is the registered data
//   busy                  operation in progress
//   done, rejected        one-cycle completion / refusal pulses
//   elim_count, score     cells removed by last command, accumulated score
//   game_over             no adjacent pair of equal colours remains
//
// Optional feature macro: COL_COMPACT_EN. When defined, empty columns are
// squeezed out to the left after gravity settles.

module board_ctrl #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned NUM_COLORS = 5,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_row,
    input  logic [2:0]         cmd_col,
    input  logic               ld_en,
    input  logic [2:0]         ld_row,
    input  logic [2:0]         ld_col,
    input  logic [2:0]         ld_color,
    input  logic [2:0]         rd_row,
    input  logic [2:0]         rd_col,
    output logic [2:0]         rd_color,
    output logic               busy,
    output logic               done,
    output logic               rejected,
    output logic [6:0]         elim_count,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;
    localparam int unsigned SUM_W = SCORE_W + 15;

    typedef enum logic [3:0] {
        StIdle, StFill, StSeed, StMark, StClear, StFall, StCompact, StCheck, StGameOver
    } state_e;

    state_e      state_q;
    logic [2:0]  board_q [64];
    logic [63:0] mark_q;
    logic [15:0] lfsr_q;
    logic [5:0]  fill_idx_q;
    logic [2:0]  tgt_row_q, tgt_col_q;

    // Bit i of the result is set when any orthogonal neighbour of cell i is set in v.
    function automatic logic [63:0] spread(input logic [63:0] v);
        return (v << 8) | (v >> 8) | ((v << 1) & ~COL0) | ((v >> 1) & ~COL7);
    endfunction

    logic [5:0]         tgt_idx;
    logic [2:0]         tgt_color;
    logic [63:0]        eq_tgt, mark_nxt;
    logic               seed_ok, has_pair;
    logic [2:0]         fall_nxt [64];
    logic               fall_moves;
    logic [6:0]         pop;
    logic [13:0]        sq;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_sat;
    logic [7:0]         fill_mod;
    logic [2:0]         fill_color;
    logic [15:0]        lfsr_nxt;
    logic [2:0]         ld_val;

    assign tgt_idx   = {tgt_row_q, tgt_col_q};
    assign tgt_color = board_q[tgt_idx];
    assign mark_nxt  = mark_q | (eq_tgt & spread(mark_q));
    assign seed_ok   = (tgt_color != 3'd0) && |(eq_tgt & spread(64'd1 << tgt_idx));

    assign pop       = 7'($countones(mark_q));
    assign sq        = {7'd0, pop} * {7'd0, pop};
    assign sum       = SUM_W'(score) + SUM_W'(sq);
    assign score_sat = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];

    assign fill_mod   = lfsr_q[7:0] % 8'(NUM_COLORS);
    assign fill_color = 3'(fill_mod + 8'd1);
    assign lfsr_nxt   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign ld_val     = (ld_color > 3'd5) ? 3'd0 : ld_color;

    assign busy      = !(state_q == StIdle || state_q == StGameOver);
    assign cmd_ready = (state_q == StIdle) && !new_game;

    always_comb begin
        has_pair = 1'b0;
        for (int i = 0; i < 64; i++) eq_tgt[i] = (board_q[i] == tgt_color);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (board_q[r*8+c] != 3'd0 && board_q[r*8+c] == board_q[r*8+c+1])
                    has_pair = 1'b1;
            end
        end
        for (int i = 0; i < 56; i++) begin
            if (board_q[i] != 3'd0 && board_q[i] == board_q[i+8]) has_pair = 1'b1;
        end
    end

    // Gravity step: per column, the bottom-most hole with something above it
    // pulls everything above it down by one row.
    always_comb begin
        logic seen, e_valid;
        int   e_row;
        fall_nxt   = board_q;
        fall_moves = 1'b0;
        for (int c = 0; c < 8; c++) begin
            seen    = 1'b0;
            e_valid = 1'b0;
            e_row   = 0;
            for (int r = 0; r < 8; r++) begin
                if (board_q[r*8+c] == 3'd0 && seen) begin
                    e_valid = 1'b1;
                    e_row   = r;
                end
                if (board_q[r*8+c] != 3'd0) seen = 1'b1;
            end
            if (e_valid) begin
                fall_nxt[c] = 3'd0;
                for (int r = 1; r < 8; r++) begin
                    if (r <= e_row) fall_nxt[r*8+c] = board_q[(r-1)*8+c];
                end
            end
            fall_moves = fall_moves | e_valid;
        end
    end

`ifdef COL_COMPACT_EN
    logic [2:0] comp_nxt [64];
    logic       comp_moves;

    // Remove the leftmost empty column that still has a nonempty column to its right.
    always_comb begin
        logic [7:0] col_empty;
        logic       right_ne;
        int         cc;
        comp_nxt   = board_q;
        comp_moves = 1'b0;
        right_ne   = 1'b0;
        cc         = 0;
        for (int c = 0; c < 8; c++) begin
            col_empty[c] = 1'b1;
            for (int r = 0; r < 8; r++) begin
                if (board_q[r*8+c] != 3'd0) col_empty[c] = 1'b0;
            end
        end
        for (int c = 7; c >= 0; c--) begin
            if (col_empty[c] && right_ne) begin
                comp_moves = 1'b1;
                cc         = c;
            end
            if (!col_empty[c]) right_ne = 1'b1;
        end
        if (comp_moves) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 7; c++) begin
                    if (c >= cc) comp_nxt[r*8+c] = board_q[r*8+c+1];
                end
                comp_nxt[r*8+7] = 3'd0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            for (int i = 0; i < 64; i++) board_q[i] <= 3'd0;
            mark_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            fill_idx_q <= '0;
            tgt_row_q  <= '0;
            tgt_col_q  <= '0;
            rd_color   <= '0;
            done       <= 1'b0;
            rejected   <= 1'b0;
            elim_count <= '0;
            score      <= '0;
            game_over  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rejected <= 1'b0;
            rd_color <= board_q[{rd_row, rd_col}];
            case (state_q)
                StIdle, StGameOver: begin
                    if (ld_en) board_q[{ld_row, ld_col}] <= ld_val;
                    if (new_game) begin
                        state_q    <= StFill;
                        fill_idx_q <= '0;
                        score      <= '0;
                        elim_count <= '0;
                        game_over  <= 1'b0;
                    end else if (state_q == StIdle && cmd_valid) begin
                        tgt_row_q <= cmd_row;
                        tgt_col_q <= cmd_col;
                        state_q   <= StSeed;
                    end
                end
                StFill: begin
                    board_q[fill_idx_q] <= fill_color;
                    lfsr_q              <= lfsr_nxt;
                    fill_idx_q          <= fill_idx_q + 6'd1;
                    if (fill_idx_q == 6'd63) state_q <= StCheck;
                end
                StSeed: begin
                    if (seed_ok) begin
                        mark_q  <= 64'd1 << tgt_idx;
                        state_q <= StMark;
                    end else begin
                        rejected <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StMark: begin
                    if (mark_nxt != mark_q) mark_q <= mark_nxt;
                    else state_q <= StClear;
                end
                StClear: begin
                    for (int i = 0; i < 64; i++) begin
                        if (mark_q[i]) board_q[i] <= 3'd0;
                    end
                    elim_count <= pop;
                    score      <= score_sat;
                    mark_q     <= '0;
                    state_q    <= StFall;
                end
                StFall: begin
                    if (fall_moves) board_q <= fall_nxt;
`ifdef COL_COMPACT_EN
                    else state_q <= StCompact;
`else
                    else state_q <= StCheck;
`endif
                end
`ifdef COL_COMPACT_EN
                StCompact: begin
                    if (comp_moves) board_q <= comp_nxt;
                    else state_q <= StCheck;
                end
`endif
                StCheck: begin
                    game_over <= !has_pair;
                    done      <= 1'b1;
                    state_q   <= has_pair ? StIdle : StGameOver;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
module tb_board_ctrl;

    logic clk = 1'b0;
    logic rst, new_game, cmd_valid, ld_en;
    logic [2:0] cmd_row, cmd_col, ld_row, ld_col, ld_color, rd_row, rd_col;

    logic        cmd_ready, busy, done, rejected, game_over;
    logic [2:0]  rd_color;
    logic [6:0]  elim_count;
    logic [15:0] score;

    logic        cmd_ready_1, busy_1, done_1, rejected_1, game_over_1;
    logic [2:0]  rd_color_1;
    logic [6:0]  elim_count_1;
    logic [15:0] score_1;

    board_ctrl #(.LFSR_SEED(16'hACE1), .NUM_COLORS(5), .SCORE_W(16)) u_dut (
        .clk(clk), .rst(rst), .new_game(new_game), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col), .ld_en(ld_en),
        .ld_row(ld_row), .ld_col(ld_col), .ld_color(ld_color), .rd_row(rd_row),
        .rd_col(rd_col), .rd_color(rd_color), .busy(busy), .done(done),
        .rejected(rejected), .elim_count(elim_count), .score(score),
        .game_over(game_over)
    );

    board_ctrl #(.LFSR_SEED(16'hACE1), .NUM_COLORS(1), .SCORE_W(16)) u_one (
        .clk(clk), .rst(rst), .new_game(new_game), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_1), .cmd_row(cmd_row), .cmd_col(cmd_col), .ld_en(ld_en),
        .ld_row(ld_row), .ld_col(ld_col), .ld_color(ld_color), .rd_row(rd_row),
        .rd_col(rd_col), .rd_color(rd_color_1), .busy(busy_1), .done(done_1),
        .rejected(rejected_1), .elim_count(elim_count_1), .score(score_1),
        .game_over(game_over_1)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        rej;
        logic [6:0]  elim;
        logic [15:0] score;
        logic        go;
    } exp_t;

    exp_t sb[$];
    int   mb[64];
    int   m_score, m_elim;
    bit   m_go;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_has_pair();
        bit p = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (c < 7 && mb[r*8+c] != 0 && mb[r*8+c] == mb[r*8+c+1]) p = 1;
                if (r < 7 && mb[r*8+c] != 0 && mb[r*8+c] == mb[(r+1)*8+c]) p = 1;
            end
        return p;
    endfunction

    task automatic model_settle();
        int col[8];
        int nb[64];
        int w;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) col[r] = 0;
            w = 7;
            for (int r = 7; r >= 0; r--)
                if (mb[r*8+c] != 0) begin col[w] = mb[r*8+c]; w--; end
            for (int r = 0; r < 8; r++) mb[r*8+c] = col[r];
        end
`ifdef COL_COMPACT_EN
        for (int i = 0; i < 64; i++) nb[i] = 0;
        w = 0;
        for (int c = 0; c < 8; c++) begin
            bit ne = 0;
            for (int r = 0; r < 8; r++) if (mb[r*8+c] != 0) ne = 1;
            if (ne) begin
                for (int r = 0; r < 8; r++) nb[r*8+w] = mb[r*8+c];
                w++;
            end
        end
        for (int i = 0; i < 64; i++) mb[i] = nb[i];
`else
        nb[0] = 0;
`endif
    endtask

    // Reference: flood fill via explicit stack, then final-state gravity.
    task automatic model_cmd(input int r, input int c);
        int tc, n, k, kr, kc;
        bit ok;
        bit mk[64];
        int stk[$];
        tc = mb[r*8+c];
        ok = 0;
        if (tc != 0) begin
            if (r > 0 && mb[(r-1)*8+c] == tc) ok = 1;
            if (r < 7 && mb[(r+1)*8+c] == tc) ok = 1;
            if (c > 0 && mb[r*8+c-1] == tc) ok = 1;
            if (c < 7 && mb[r*8+c+1] == tc) ok = 1;
        end
        if (!ok) begin
            sb.push_back({1'b1, 7'(m_elim), 16'(m_score), m_go});
            return;
        end
        for (int i = 0; i < 64; i++) mk[i] = 0;
        mk[r*8+c] = 1;
        stk.push_back(r*8+c);
        n = 0;
        while (stk.size() > 0) begin
            k = stk.pop_back();
            n++;
            kr = k / 8;
            kc = k % 8;
            if (kr > 0 && !mk[k-8] && mb[k-8] == tc) begin mk[k-8] = 1; stk.push_back(k-8); end
            if (kr < 7 && !mk[k+8] && mb[k+8] == tc) begin mk[k+8] = 1; stk.push_back(k+8); end
            if (kc > 0 && !mk[k-1] && mb[k-1] == tc) begin mk[k-1] = 1; stk.push_back(k-1); end
            if (kc < 7 && !mk[k+1] && mb[k+1] == tc) begin mk[k+1] = 1; stk.push_back(k+1); end
        end
        for (int i = 0; i < 64; i++) if (mk[i]) mb[i] = 0;
        model_settle();
        m_elim  = n;
        m_score = (m_score + n*n > 65535) ? 65535 : m_score + n*n;
        m_go    = !model_has_pair();
        sb.push_back({1'b0, 7'(m_elim), 16'(m_score), m_go});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mb[i] = 0;
        m_score = 0;
        m_elim  = 0;
        m_go    = 0;
        sb.delete();
    endtask

    task automatic ld_cell(input int r, input int c, input int v);
        ld_en    = 1'b1;
        ld_row   = 3'(r);
        ld_col   = 3'(c);
        ld_color = 3'(v);
        @(posedge clk); #1;
        ld_en = 1'b0;
        mb[r*8+c] = (v > 5) ? 0 : v;
    endtask

    task automatic check_board(input string tag);
        for (int i = 0; i < 64; i++) begin
            rd_row = 3'(i / 8);
            rd_col = 3'(i % 8);
            @(posedge clk); #1;
            chk($sformatf("%s cell%0d", tag, i), rd_color, mb[i]);
        end
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, " rejected"}, rejected, e.rej);
        chk({tag, " done"}, done, !e.rej);
        chk({tag, " elim"}, elim_count, e.elim);
        chk({tag, " score"}, score, e.score);
        chk({tag, " game_over"}, game_over, e.go);
    endtask

    task automatic wait_result(input string tag);
        bit seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk); #1;
            if (done || rejected) seen = 1;
        end
        chk({tag, " response"}, seen, 1);
        if (seen) compare_result(tag);
        @(posedge clk); #1;
        chk({tag, " pulse width"}, {done, rejected}, 0);
    endtask

    task automatic run_cmd(input string tag, input int r, input int c);
        model_cmd(r, c);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_row   = 3'(r);
        cmd_col   = 3'(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_result(tag);
    endtask

    initial begin
        int n_resp, busy_n, done_n, rej_n;
        bit saw_done;
        logic [15:0] l;
        rst = 1'b0; new_game = 1'b0; cmd_valid = 1'b0; ld_en = 1'b0;
        cmd_row = '0; cmd_col = '0; ld_row = '0; ld_col = '0; ld_color = '0;
        rd_row = '0; rd_col = '0;
        #2;
        do_reset();

        // Reset state
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rejected", rejected, 0);
        chk("rst score", score, 0);
        chk("rst elim", elim_count, 0);
        chk("rst game_over", game_over, 0);
        chk("rst cmd_ready", cmd_ready, 1);

        // Empty board: command refused
        run_cmd("empty", 0, 0);
        check_board("empty");

        // Checkerboard: no equal neighbours anywhere
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) ld_cell(r, c, ((r + c) % 2 == 0) ? 1 : 2);
        run_cmd("checker", 0, 0);
        check_board("checker");

        // Two-cell group at the bottom-left
        ld_cell(7, 0, 3);
        ld_cell(7, 1, 3);
        run_cmd("pair", 7, 0);
        chk("pair elim const", elim_count, 2);
        chk("pair score const", score, 4);
        check_board("pair");

        // Whole board one colour: everything goes, game over
        do_reset();
        for (int i = 0; i < 64; i++) ld_cell(i / 8, i % 8, (i == 9) ? 7 : 1);
        chk("ld 7 stored as 0 model", mb[9], 0);
        ld_cell(1, 1, 1);
        run_cmd("allones", 3, 3);
        chk("allones score const", score, 4096);
        chk("allones cmd_ready", cmd_ready, 0);
        chk("allones busy", busy, 0);
        cmd_valid = 1'b1;
        n_resp = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || rejected || busy) n_resp++;
        end
        cmd_valid = 1'b0;
        chk("gameover ignores cmd", n_resp, 0);
        check_board("allones");

        // Reset in the middle of MARK
        do_reset();
        for (int i = 0; i < 64; i++) ld_cell(i / 8, i % 8, 1);
        cmd_valid = 1'b1; cmd_row = 3'd3; cmd_col = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid busy before rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid busy in rst", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mb[i] = 0;
        saw_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        chk("mid no done", saw_done, 0);
        chk("mid score", score, 0);
        check_board("midrst");

        // new_game beats a simultaneous command; fill from the seed
        do_reset();
        l = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
            mb[i] = int'(l[7:0]) % 5 + 1;
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        m_score = 0; m_elim = 0; m_go = !model_has_pair();
        sb.push_back({1'b0, 7'(m_elim), 16'(m_score), m_go});
        new_game = 1'b1; cmd_valid = 1'b1; cmd_row = 3'd0; cmd_col = 3'd0;
        #1;
        chk("ng cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        new_game = 1'b0; cmd_valid = 1'b0;
        busy_n = 0; done_n = 0; rej_n = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy_1) busy_n++;
            if (rejected_1 || rejected) rej_n++;
            if (done_1) begin done_n++; break; end
            @(posedge clk); #1;
        end
        chk("fill busy cycles", busy_n, 65);
        chk("fill done1", done_n, 1);
        chk("fill no reject", rej_n, 0);
        chk("fill1 score", score_1, 0);
        chk("fill1 game_over", game_over_1, 0);
        compare_result("fill");
        @(posedge clk); #1;
        chk("fill idle", {busy, busy_1, done, done_1}, 0);
        for (int i = 0; i < 64; i++) begin
            rd_row = 3'(i / 8);
            rd_col = 3'(i % 8);
            @(posedge clk); #1;
            chk($sformatf("fill cell%0d", i), rd_color, mb[i]);
            chk($sformatf("fill1 cell%0d", i), rd_color_1, 1);
        end

`ifdef COL_COMPACT_EN
        // Column 0 cleared out; remaining columns slide left
        do_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ld_cell(r, c, (c == 0) ? 1 : (((r + c) % 2 == 0) ? 1 : 2));
        run_cmd("compact", 0, 0);
        check_board("compact");
        for (int r = 0; r < 8; r++) chk($sformatf("compact col7 r%0d", r), mb[r*8+7], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
